fib_stream_gen: RTL and testbench

Parametrised Fibonacci stream generator. Successor to the fixed 32-bit odd-term generator. Walks the first `n` Fibonacci terms, one term per cycle, and emits the terms selected by a runtime filter mode. Results go out over the standard generator handshake (`__start` / `__valid` / `__ready` / `__done`). It sits alongside the other generated generator blocks and feeds any ready/valid consumer.

---
 rtl/fib_stream_gen.sv | 130 +++++++++++++
 tb/tb_fib_stream_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_stream_gen.sv
// Fibonacci stream generator: walks F0..F(n-1) and emits terms selected by a runtime filter
// over a valid/ready handshake. Define FIB_STREAM_OVERFLOW_EN to stop the run on width overflow.
module fib_stream_gen #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             __clock,
    input  logic             __reset,
    input  logic             __start,
    input  logic [CNT_W-1:0] n,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] k,
    input  logic             __ready,
    output logic             __valid,
    output logic             __done,
    output logic             __overflow,
    output logic [WIDTH-1:0] __output_0,
    output logic [CNT_W-1:0] __output_1
);

    typedef enum logic [1:0] {ST_START, ST_RUN, ST_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] i;
    logic [CNT_W-1:0] kc;
    logic [CNT_W-1:0] n_l;
    logic [CNT_W-1:0] k_l;
    logic [CNT_W-1:0] k_eff;
    logic [1:0]       mode_l;
    logic             a_ovf;
    logic             b_ovf;
    logic             carry;
    logic             adv;
    logic             match;

`ifdef FIB_STREAM_OVERFLOW_EN
    logic [WIDTH:0] sum_full;
    assign sum_full = {1'b0, a} + {1'b0, b};
    assign sum      = sum_full[WIDTH-1:0];
    assign carry    = sum_full[WIDTH];
`else
    // No carry source: the ovf flags never leave 0 and terms wrap modulo 2^WIDTH.
    assign sum   = a + b;
    assign carry = 1'b0;
`endif

    assign adv   = __ready | ~__valid;
    assign k_eff = (k_l == '0) ? CNT_W'(1) : k_l;

    always_comb begin
        match = 1'b0;
        case (mode_l)
            2'b00:   match = 1'b1;
            2'b01:   match = ~a[0];
            2'b10:   match = a[0];
            default: match = (kc == '0);
        endcase
    end

    always_ff @(posedge __clock) begin
        if (__reset) begin
            state      <= ST_START;
            __valid    <= 1'b0;
            __done     <= 1'b0;
            __overflow <= 1'b0;
            __output_0 <= '0;
            __output_1 <= '0;
            a          <= '0;
            b          <= '0;
            i          <= '0;
            kc         <= '0;
            n_l        <= '0;
            k_l        <= '0;
            mode_l     <= '0;
            a_ovf      <= 1'b0;
            b_ovf      <= 1'b0;
        end else if (adv) begin
            case (state)
                ST_START: begin
                    n_l    <= n;
                    mode_l <= mode;
                    k_l    <= k;
                    if (__start) begin
                        a     <= '0;
                        b     <= WIDTH'(1);
                        i     <= '0;
                        kc    <= '0;
                        a_ovf <= 1'b0;
                        b_ovf <= 1'b0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i < n_l && !a_ovf) begin
                        __valid    <= match;
                        __done     <= 1'b0;
                        __overflow <= 1'b0;
                        __output_0 <= a;
                        __output_1 <= i;
                        a          <= b;
                        b          <= sum;
                        a_ovf      <= b_ovf;
                        b_ovf      <= b_ovf | carry;
                        i          <= i + CNT_W'(1);
                        kc         <= (kc == k_eff - CNT_W'(1)) ? '0 : kc + CNT_W'(1);
                    end else begin
                        __valid    <= 1'b1;
                        __done     <= 1'b1;
                        __overflow <= a_ovf;
                        __output_0 <= '0;
                        __output_1 <= i;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // valid is high here, so advancing means the done beat was accepted.
                    __valid    <= 1'b0;
                    __done     <= 1'b0;
                    __overflow <= 1'b0;
                    state      <= ST_START;
                end
                default: state <= ST_START;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_stream_gen.sv
// Scoreboard bench for fib_stream_gen: two instances (32-bit and 8-bit terms) driven in lockstep,
// expected beats come from an exact-arithmetic Fibonacci model.
module tb_fib_stream_gen;

    typedef struct {
        bit              done;
        bit              ovf;
        longint unsigned val;
        int unsigned     idx;
    } exp_t;

`ifdef FIB_STREAM_OVERFLOW_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] n = '0;
    logic [1:0]  mode = '0;
    logic [31:0] k = '0;
    logic        ready = 1'b1;

    logic        v32, d32, o32;
    logic [31:0] out0_32, out1_32;
    logic        v8, d8, o8;
    logic [7:0]  out0_8;
    logic [31:0] out1_8;

    exp_t q32[$];
    exp_t q8[$];
    int   total = 0;
    int   bad = 0;
    bit   seen32 = 1'b0;
    bit   seen8 = 1'b0;
    int   rdy_mode = 0;
    int   rdy_cnt = 0;

    fib_stream_gen #(.WIDTH(32), .CNT_W(32)) dut32 (
        .__clock(clk), .__reset(rst), .__start(start), .n(n), .mode(mode), .k(k),
        .__ready(ready), .__valid(v32), .__done(d32), .__overflow(o32),
        .__output_0(out0_32), .__output_1(out1_32)
    );

    fib_stream_gen #(.WIDTH(8), .CNT_W(32)) dut8 (
        .__clock(clk), .__reset(rst), .__start(start), .n(n), .mode(mode), .k(k),
        .__ready(ready), .__valid(v8), .__done(d8), .__overflow(o8),
        .__output_0(out0_8), .__output_1(out1_8)
    );

    always #5 clk = ~clk;

    // ready pattern: 0 = always high, 1 = 1,0,0,1 repeating, 2 = random
    always @(posedge clk) begin
        #1;
        rdy_cnt++;
        case (rdy_mode)
            0:       ready = 1'b1;
            1:       ready = ((rdy_cnt % 4) == 0) || ((rdy_cnt % 4) == 3);
            default: ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic push_model(input int w, input int unsigned nn, input logic [1:0] md,
                              input int unsigned kk);
        longint unsigned f0 = 0, f1 = 1, t, lim;
        int unsigned ke;
        bit m;
        exp_t e;
        lim = 64'd1 << w;
        ke = (kk == 0) ? 1 : kk;
        for (int unsigned idx = 0; idx < 1000; idx++) begin
            if (idx >= nn || (OVF && f0 >= lim)) begin
                e = '{done: 1'b1, ovf: (OVF && f0 >= lim), val: 64'd0, idx: idx};
                if (w == 32) q32.push_back(e); else q8.push_back(e);
                break;
            end
            case (md)
                2'b00:   m = 1'b1;
                2'b01:   m = (f0 % 2) == 0;
                2'b10:   m = (f0 % 2) == 1;
                default: m = (idx % ke) == 0;
            endcase
            if (m) begin
                e = '{done: 1'b0, ovf: 1'b0, val: f0 % lim, idx: idx};
                if (w == 32) q32.push_back(e); else q8.push_back(e);
            end
            t = f0 + f1;
            f0 = f1;
            f1 = t;
        end
    endtask

    task automatic mon(input int w, input logic v, input logic d, input logic o,
                       input longint unsigned val, input logic [31:0] idx);
        exp_t e;
        if (!v || rst) return;
        total++;
        if ((w == 32) ? (q32.size() == 0) : (q8.size() == 0)) begin
            bad++;
            $display("FAIL beat_w%0d unexpected beat val=%0d idx=%0d done=%0b", w, val, idx, d);
            return;
        end
        e = (w == 32) ? q32[0] : q8[0];
        if (val !== e.val || idx !== e.idx || d !== e.done || o !== e.ovf) begin
            bad++;
            $display("FAIL beat_w%0d got val=%0d idx=%0d done=%0b ovf=%0b want val=%0d idx=%0d done=%0b ovf=%0b",
                     w, val, idx, d, o, e.val, e.idx, e.done, e.ovf);
        end
        if (ready) begin
            if (w == 32) void'(q32.pop_front()); else void'(q8.pop_front());
            if (d) begin
                if (w == 32) seen32 = 1'b1; else seen8 = 1'b1;
            end
        end
    endtask

    always @(negedge clk) mon(32, v32, d32, o32, 64'(out0_32), out1_32);
    always @(negedge clk) mon(8, v8, d8, o8, 64'(out0_8), out1_8);

    task automatic check_idle(input string name);
        total++;
        if ({v32, d32, o32, out0_32, out1_32} !== '0) begin
            bad++;
            $display("FAIL %s_w32 got v=%0b d=%0b o=%0b out0=%0d out1=%0d want all 0",
                     name, v32, d32, o32, out0_32, out1_32);
        end
        total++;
        if ({v8, d8, o8, out0_8, out1_8} !== '0) begin
            bad++;
            $display("FAIL %s_w8 got v=%0b d=%0b o=%0b out0=%0d out1=%0d want all 0",
                     name, v8, d8, o8, out0_8, out1_8);
        end
    endtask

    task automatic clear_sb();
        q32.delete();
        q8.delete();
        seen32 = 1'b0;
        seen8 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_sb();
    endtask

    task automatic kick(input int unsigned nn, input logic [1:0] md, input int unsigned kk,
                        input int rm);
        @(posedge clk);
        #1;
        rdy_mode = rm;
        n = nn;
        mode = md;
        k = kk;
        seen32 = 1'b0;
        seen8 = 1'b0;
        push_model(32, nn, md, kk);
        push_model(8, nn, md, kk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // scramble the configuration mid-run; the latched copy must be used
        n = $urandom;
        mode = 2'($urandom);
        k = $urandom_range(0, 7);
    endtask

    task automatic run(input int unsigned nn, input logic [1:0] md, input int unsigned kk,
                       input int rm);
        int c;
        kick(nn, md, kk, rm);
        for (c = 0; c < 3000; c++) begin
            if (seen32 && seen8) break;
            @(posedge clk);
        end
        total++;
        if (!(seen32 && seen8)) begin
            bad++;
            $display("FAIL run_timeout n=%0d mode=%0d got done32=%0b done8=%0b want both 1",
                     nn, md, seen32, seen8);
            do_reset();
        end
        total++;
        if (q32.size() != 0 || q8.size() != 0) begin
            bad++;
            $display("FAIL run_leftover n=%0d mode=%0d got pending32=%0d pending8=%0d want 0",
                     nn, md, q32.size(), q8.size());
        end
        clear_sb();
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_state");
        rst = 1'b0;

        run(10, 2'b00, 0, 0);
        run(10, 2'b01, 0, 0);
        run(10, 2'b10, 0, 0);
        run(10, 2'b11, 3, 0);
        run(0, 2'b00, 0, 0);
        run(10, 2'b11, 0, 0);
        run(20, 2'b00, 0, 0);
        run(60, 2'b00, 0, 0);
        run(10, 2'b00, 0, 1);
        run(20, 2'b10, 0, 1);

        // reset in the middle of a run, then replay from index 0
        kick(10, 2'b00, 0, 0);
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            if (v32 && out1_32 == 32'd5) break;
        end
        total++;
        if (!(v32 && out1_32 == 32'd5)) begin
            bad++;
            $display("FAIL reset_wait got idx=%0d valid=%0b want idx=5 valid=1", out1_32, v32);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle("mid_reset");
        rst = 1'b0;
        clear_sb();
        @(posedge clk);
        #1;
        run(10, 2'b00, 0, 0);

        for (int r = 0; r < 14; r++)
            run($urandom_range(0, 60), 2'($urandom_range(0, 3)), $urandom_range(0, 5),
                $urandom_range(0, 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
